// File: rtl/vga_timing_gen_pkg.sv
// Shared definitions for the VGA raster timing path: axis state encoding and
// the default 640x480@60 timing, also read by the colour driver.
package vga_timing_gen_pkg;

  typedef enum logic [1:0] {
    AX_ACTIVE = 2'd0,
    AX_FRONT  = 2'd1,
    AX_SYNC   = 2'd2,
    AX_BACK   = 2'd3
  } axis_state_e;

  localparam int unsigned CNT_W     = 10;
  localparam int unsigned MAX_TOTAL = 1 << CNT_W;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_CLK_DIV  = 2;
  localparam int unsigned DEF_SYNC_DLY = 1;

endpackage

// File: rtl/vga_axis_fsm.sv
// One raster axis: a wrapping position counter plus the ACTIVE/FRONT/SYNC/BACK
// phase, both stepped by advance. Used once for H and once for V.
module vga_axis_fsm
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       advance,
  output logic [9:0] count,
  output logic [1:0] state,
  output logic       wrap
);

  localparam int unsigned TOTAL    = ACTIVE + FP + SYNC + BP;
  localparam logic [9:0]  LAST     = 10'(TOTAL - 1);
  localparam logic [9:0]  FRONT_AT = 10'(ACTIVE);
  localparam logic [9:0]  SYNC_AT  = 10'(ACTIVE + FP);
  localparam logic [9:0]  BACK_AT  = 10'(ACTIVE + FP + SYNC);

  logic [9:0]  count_q, count_d;
  axis_state_e state_q, state_d;

  assign wrap  = (count_q == LAST);
  assign count = count_q;
  assign state = state_q;

  // Phase is decided from the count being loaded, so it always agrees with count.
  always_comb begin
    count_d = count_q;
    state_d = state_q;
    if (advance) begin
      count_d = wrap ? '0 : count_q + 10'd1;
      if (count_d == '0)            state_d = AX_ACTIVE;
      else if (count_d == FRONT_AT) state_d = AX_FRONT;
      else if (count_d == SYNC_AT)  state_d = AX_SYNC;
      else if (count_d == BACK_AT)  state_d = AX_BACK;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      count_q <= LAST;
      state_q <= AX_BACK;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel clock divider, H/V axis sequencers, and the
// enable / sync / frame_start decode feeding the colour driver.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned SYNC_DLY = DEF_SYNC_DLY
) (
  input  logic       clk_in,
  input  logic       reset,
  output logic       pixel_tick,
  output logic [9:0] current_row,
  output logic [9:0] current_line,
  output logic       enable,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must each be <= 1024");
  end
  if (CLK_DIV < 1 || SYNC_DLY > 1) begin : g_param_check
    $error("vga_timing_gen: CLK_DIV must be >= 1 and SYNC_DLY 0 or 1");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic             advance;
  logic             pixel_tick_q, frame_start_q;
  logic             hsync_dly_q, vsync_dly_q;
  logic [1:0]       h_state, v_state;
  logic             h_wrap, v_wrap;
  logic             hsync_raw, vsync_raw;

  // advance is the edge on which raster state moves; pixel_tick marks that clk.
  assign advance = (div_q == DIV_LAST);
  assign div_d   = advance ? '0 : div_q + DIV_W'(1);

  vga_axis_fsm #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk_in  (clk_in),
    .reset   (reset),
    .advance (advance),
    .count   (current_row),
    .state   (h_state),
    .wrap    (h_wrap)
  );

  vga_axis_fsm #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk_in  (clk_in),
    .reset   (reset),
    .advance (advance & h_wrap),
    .count   (current_line),
    .state   (v_state),
    .wrap    (v_wrap)
  );

  assign hsync_raw = (h_state != AX_SYNC);
  assign vsync_raw = (v_state != AX_SYNC);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      div_q         <= '0;
      pixel_tick_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hsync_dly_q   <= 1'b1;
      vsync_dly_q   <= 1'b1;
    end else begin
      div_q         <= div_d;
      pixel_tick_q  <= advance;
      frame_start_q <= advance & h_wrap & v_wrap;
      if (advance) begin
        hsync_dly_q <= hsync_raw;
        vsync_dly_q <= vsync_raw;
      end
    end
  end

  assign pixel_tick  = pixel_tick_q;
  assign frame_start = frame_start_q;
  assign enable      = (h_state == AX_ACTIVE) && (v_state == AX_ACTIVE);
  assign hsync       = (SYNC_DLY != 0) ? hsync_dly_q : hsync_raw;
  assign vsync       = (SYNC_DLY != 0) ? vsync_dly_q : vsync_raw;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default mode plus two shrunken rasters, all compared
// every clk against an arithmetic model of the raster indexed by clks since reset.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, div, dly;
  } geom_t;

  typedef struct {
    int tick, row, line, en, hs, vs, fs;
  } exp_t;

  typedef struct {
    bit rst;
    int ncyc;
    int tick, row, line, en, hs, vs, fs;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       d_tick, d_en, d_hs, d_vs, d_fs;
  logic [9:0] d_row, d_line;
  logic       a_tick, a_en, a_hs, a_vs, a_fs;
  logic [9:0] a_row, a_line;
  logic       b_tick, b_en, b_hs, b_vs, b_fs;
  logic [9:0] b_row, b_line;

  int checks = 0;
  int errors = 0;
  int n = 0;

  geom_t g_def, g_a, g_b;
  vec_t  vecs[$];

  vga_timing_gen #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
    .CLK_DIV(2), .SYNC_DLY(1)
  ) u_def (
    .clk_in(clk), .reset(reset), .pixel_tick(d_tick), .current_row(d_row),
    .current_line(d_line), .enable(d_en), .hsync(d_hs), .vsync(d_vs), .frame_start(d_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .CLK_DIV(1), .SYNC_DLY(0)
  ) u_a (
    .clk_in(clk), .reset(reset), .pixel_tick(a_tick), .current_row(a_row),
    .current_line(a_line), .enable(a_en), .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .CLK_DIV(3), .SYNC_DLY(1)
  ) u_b (
    .clk_in(clk), .reset(reset), .pixel_tick(b_tick), .current_row(b_row),
    .current_line(b_line), .enable(b_en), .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs)
  );

  // Pixel index p = ticks-1 since reset; position and sync follow from p by division.
  function automatic exp_t model(input geom_t g, input int cyc);
    exp_t e;
    int ht, vt, ticks, p, q, qr, ql;
    ht = g.ha + g.hf + g.hs + g.hb;
    vt = g.va + g.vf + g.vs + g.vb;
    ticks = cyc / g.div;
    e.tick = (cyc >= 1 && (cyc % g.div) == 0) ? 1 : 0;
    if (ticks == 0) begin
      e.row = ht - 1; e.line = vt - 1; e.en = 0; e.hs = 1; e.vs = 1; e.fs = 0;
      return e;
    end
    p = ticks - 1;
    e.row  = p % ht;
    e.line = (p / ht) % vt;
    e.en   = (e.row < g.ha && e.line < g.va) ? 1 : 0;
    e.fs   = (e.tick == 1 && (p % (ht * vt)) == 0) ? 1 : 0;
    q = p - g.dly;
    if (q < 0) begin
      e.hs = 1; e.vs = 1;
    end else begin
      qr = q % ht;
      ql = (q / ht) % vt;
      e.hs = (qr >= g.ha + g.hf && qr < g.ha + g.hf + g.hs) ? 0 : 1;
      e.vs = (ql >= g.va + g.vf && ql < g.va + g.vf + g.vs) ? 0 : 1;
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (clk %0d after reset)", name, act, req, n);
    end
  endtask

  task automatic chk_inst(input string tag, input exp_t e, input int tick, input int row,
                          input int line, input int en, input int hs, input int vs, input int fs);
    chk({tag, ".pixel_tick"},   tick, e.tick);
    chk({tag, ".current_row"},  row,  e.row);
    chk({tag, ".current_line"}, line, e.line);
    chk({tag, ".enable"},       en,   e.en);
    chk({tag, ".hsync"},        hs,   e.hs);
    chk({tag, ".vsync"},        vs,   e.vs);
    chk({tag, ".frame_start"},  fs,   e.fs);
  endtask

  task automatic check_all();
    chk_inst("def", model(g_def, n), int'(d_tick), int'(d_row), int'(d_line),
             int'(d_en), int'(d_hs), int'(d_vs), int'(d_fs));
    chk_inst("a", model(g_a, n), int'(a_tick), int'(a_row), int'(a_line),
             int'(a_en), int'(a_hs), int'(a_vs), int'(a_fs));
    chk_inst("b", model(g_b, n), int'(b_tick), int'(b_row), int'(b_line),
             int'(b_en), int'(b_hs), int'(b_vs), int'(b_fs));
  endtask

  task automatic step(input bit r);
    reset = r;
    @(posedge clk);
    #1;
    n = r ? 0 : n + 1;
    check_all();
  endtask

  function automatic int fs_of(input int which);
    return (which == 0) ? int'(a_fs) : int'(b_fs);
  endfunction

  task automatic measure_fs(input int which, input int req, input string name);
    int first;
    bit done;
    first = -1;
    done = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      step(1'b0);
      if (fs_of(which) == 1) begin
        if (first < 0) first = i;
        else begin
          chk(name, i - first, req);
          done = 1;
        end
      end
    end
    if (!done) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int vs_low, en_cnt;
    g_def = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1};
    g_a   = '{10, 2, 3, 4, 6, 1, 2, 2, 1, 0};
    g_b   = '{10, 2, 3, 4, 6, 1, 2, 2, 3, 1};

    // rst, cycles, tick, row, line, en, hs, vs, fs -- default instance after last cycle
    vecs.push_back('{1'b1,    2, 0, 799, 524, 0, 1, 1, 0});
    vecs.push_back('{1'b0,    1, 0, 799, 524, 0, 1, 1, 0});
    vecs.push_back('{1'b0,    1, 1,   0,   0, 1, 1, 1, 1});
    vecs.push_back('{1'b0,    1, 0,   0,   0, 1, 1, 1, 0});
    vecs.push_back('{1'b0, 1277, 1, 639,   0, 1, 1, 1, 0});
    vecs.push_back('{1'b0,    2, 1, 640,   0, 0, 1, 1, 0});
    vecs.push_back('{1'b0,   32, 1, 656,   0, 0, 1, 1, 0});
    vecs.push_back('{1'b0,    2, 1, 657,   0, 0, 0, 1, 0});
    vecs.push_back('{1'b0,  190, 1, 752,   0, 0, 0, 1, 0});
    vecs.push_back('{1'b0,    2, 1, 753,   0, 0, 1, 1, 0});
    vecs.push_back('{1'b0,   92, 1, 799,   0, 0, 1, 1, 0});
    vecs.push_back('{1'b0,    2, 1,   0,   1, 1, 1, 1, 0});
    vecs.push_back('{1'b1,    1, 0, 799, 524, 0, 1, 1, 0});
    vecs.push_back('{1'b0,    2, 1,   0,   0, 1, 1, 1, 1});

    for (int i = 0; i < vecs.size(); i++) begin
      for (int c = 0; c < vecs[i].ncyc; c++) step(vecs[i].rst);
      chk($sformatf("vec%0d.pixel_tick", i),   int'(d_tick), vecs[i].tick);
      chk($sformatf("vec%0d.current_row", i),  int'(d_row),  vecs[i].row);
      chk($sformatf("vec%0d.current_line", i), int'(d_line), vecs[i].line);
      chk($sformatf("vec%0d.enable", i),       int'(d_en),   vecs[i].en);
      chk($sformatf("vec%0d.hsync", i),        int'(d_hs),   vecs[i].hs);
      chk($sformatf("vec%0d.vsync", i),        int'(d_vs),   vecs[i].vs);
      chk($sformatf("vec%0d.frame_start", i),  int'(d_fs),   vecs[i].fs);
    end

    // Random stimulus with occasional mid-frame resets
    for (int i = 0; i < 6000; i++) step(($urandom_range(0, 1499) == 0) ? 1'b1 : 1'b0);

    step(1'b1);
    measure_fs(1, 19 * 11 * 3, "b.frame_period");
    measure_fs(0, 19 * 11, "a.frame_period");

    vs_low = 0;
    en_cnt = 0;
    for (int i = 0; i < 19 * 11; i++) begin
      step(1'b0);
      if (a_vs == 1'b0) vs_low++;
      if (a_en == 1'b1) en_cnt++;
    end
    chk("a.vsync_low_per_frame", vs_low, 2 * 19);
    chk("a.enable_per_frame", en_cnt, 10 * 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
